// File: rtl/spi_master_sched_pkg.sv
// Shared register map, widths and FSM encoding for the spi_master request scheduler.
package spi_master_sched_pkg;

    localparam int unsigned SPI_ADDR_W = 3;
    localparam int unsigned SPI_DATA_W = 32;

    localparam logic [SPI_ADDR_W-1:0] SPI_TX         = 3'd0;
    localparam logic [SPI_ADDR_W-1:0] SPI_RX         = 3'd1;
    localparam logic [SPI_ADDR_W-1:0] SPI_READY      = 3'd2;
    localparam logic [SPI_ADDR_W-1:0] SPI_INTRRPT_EN = 3'd3;

    // StPollChk is the cycle in which the registered READY read comes back.
    typedef enum logic [3:0] {
        StInit,
        StIdle,
        StArb,
        StWrTx,
        StGap,
        StPoll,
        StPollChk,
        StRdRx,
        StRdCap,
        StRsp
    } sched_state_e;

    function automatic int unsigned cnt_width(input int unsigned timeout_cyc);
        return $clog2(timeout_cyc + 1);
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after rr_ptr, wrapping.
module spi_rr_arbiter #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_idx,
    output logic                     any_req
);

    localparam int unsigned IdxW = $clog2(N_REQ);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        idx       = 0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            idx = (int'(rr_ptr) + k) % int'(N_REQ);
            if (!any_req && req[idx]) begin
                any_req        = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = IdxW'(idx);
            end
        end
    end

endmodule

// File: rtl/spi_master_sched.sv
// Shares one spi_master register port among N_REQ requesters, one transfer at a time:
// write TX, gap, poll READY, read RX, respond to the owner.
module spi_master_sched
    import spi_master_sched_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*SPI_DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]             req_ready,
    output logic [N_REQ-1:0]             rsp_valid,
    output logic [SPI_DATA_W-1:0]        rsp_data,
    output logic                         rsp_err,
    output logic                         busy,
    output logic [SPI_ADDR_W-1:0]        m_address,
    output logic [SPI_DATA_W-1:0]        m_data_in,
    output logic                         m_sel,
    output logic                         m_we,
    input  logic [SPI_DATA_W-1:0]        m_data_out
);

    localparam int unsigned IdxW = $clog2(N_REQ);
    localparam int unsigned CntW = cnt_width(TIMEOUT_CYC);

    sched_state_e          state_q, state_d;
    logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]       grant_idx_q, grant_idx_d;
    logic [N_REQ-1:0]      grant_oh_q, grant_oh_d;
    logic [SPI_DATA_W-1:0] word_q, word_d;
    logic [CntW-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [SPI_DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;

    logic [N_REQ-1:0]      arb_grant;
    logic [IdxW-1:0]       arb_idx;
    logic                  arb_any;

    logic [N_REQ-1:0]      req_ready_c, rsp_valid_c;
    logic [SPI_ADDR_W-1:0] m_address_c;
    logic [SPI_DATA_W-1:0] m_data_in_c;
    logic                  m_sel_c, m_we_c, busy_c;

    spi_rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_arb (
        .req      (req_valid),
        .rr_ptr   (rr_ptr_q),
        .grant    (arb_grant),
        .grant_idx(arb_idx),
        .any_req  (arb_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StInit;
            rr_ptr_q    <= IdxW'(N_REQ - 1);
            grant_idx_q <= '0;
            grant_oh_q  <= '0;
            word_q      <= '0;
            cnt_q       <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            grant_oh_q  <= grant_oh_d;
            word_q      <= word_d;
            cnt_q       <= cnt_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        grant_oh_d  = grant_oh_q;
        word_d      = word_q;
        cnt_d       = cnt_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        req_ready_c = '0;
        rsp_valid_c = '0;
        m_address_c = '0;
        m_data_in_c = '0;
        m_sel_c     = 1'b0;
        m_we_c      = 1'b0;
        busy_c      = (state_q != StIdle);

        unique case (state_q)
            StInit: begin
                m_address_c = SPI_INTRRPT_EN;
                m_sel_c     = 1'b1;
                m_we_c      = 1'b1;
                state_d     = StIdle;
            end
            StIdle: begin
                if (|req_valid) state_d = StArb;
            end
            StArb: begin
                if (arb_any) begin
                    grant_oh_d  = arb_grant;
                    grant_idx_d = arb_idx;
                    word_d      = req_data[int'(arb_idx)*SPI_DATA_W +: SPI_DATA_W];
                    state_d     = StWrTx;
                end else begin
                    state_d = StIdle;
                end
            end
            StWrTx: begin
                m_address_c = SPI_TX;
                m_data_in_c = word_q;
                m_sel_c     = 1'b1;
                m_we_c      = 1'b1;
                req_ready_c = grant_oh_q;
                state_d     = StGap;
            end
            // Deselect for a cycle so a READY left over from the last transfer is never seen.
            StGap: begin
                state_d = StPoll;
            end
            StPoll: begin
                m_address_c = SPI_READY;
                m_sel_c     = 1'b1;
                state_d     = StPollChk;
            end
            StPollChk: begin
                if (m_data_out != '0) begin
                    state_d = StRdRx;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CntW'(TIMEOUT_CYC)) begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        state_d    = StRsp;
                    end else begin
                        state_d = StPoll;
                    end
                end
            end
            StRdRx: begin
                m_address_c = SPI_RX;
                m_sel_c     = 1'b1;
                state_d     = StRdCap;
            end
            StRdCap: begin
                rsp_data_d = m_data_out;
                rsp_err_d  = 1'b0;
                state_d    = StRsp;
            end
            StRsp: begin
                rsp_valid_c = grant_oh_q;
                rr_ptr_d    = grant_idx_q;
                cnt_d       = '0;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Reset forces every output low at once, even though the state register sits in StInit.
    assign req_ready = rst ? req_ready_c : '0;
    assign rsp_valid = rst ? rsp_valid_c : '0;
    assign m_address = rst ? m_address_c : '0;
    assign m_data_in = rst ? m_data_in_c : '0;
    assign m_sel     = m_sel_c & rst;
    assign m_we      = m_we_c & rst;
    assign busy      = busy_c & rst;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_spi_master_sched.sv
// Bench for spi_master_sched: stub spi_master with loopback slave, round-robin reference model.
module tb_spi_master_sched;
    import spi_master_sched_pkg::*;

    localparam int NR = 4;
    localparam int TO = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NR-1:0]        req_valid = '0;
    logic [NR*32-1:0]     req_data = '0;
    logic [NR-1:0]        req_ready, rsp_valid;
    logic [31:0]          rsp_data;
    logic                 rsp_err, busy;
    logic [SPI_ADDR_W-1:0] m_address;
    logic [31:0]          m_data_in;
    logic                 m_sel, m_we;
    logic [31:0]          m_data_out = '0;

    spi_master_sched #(
        .N_REQ      (NR),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .m_address (m_address),
        .m_data_in (m_data_in),
        .m_sel     (m_sel),
        .m_we      (m_we),
        .m_data_out(m_data_out)
    );

    always #5 clk = ~clk;

    // Stub master: a TX write swaps the slave shift register; READY stays 0 for ready_delay polls.
    logic [31:0] slave_q = '0;
    logic [31:0] rx_q = '0;
    int          reads_left = 0;
    int          ready_delay = 0;

    always @(posedge clk) begin
        if (m_sel) begin
            if (m_we) begin
                if (m_address == SPI_TX) begin
                    rx_q       <= slave_q;
                    slave_q    <= m_data_in;
                    reads_left <= ready_delay;
                end
            end else if (m_address == SPI_READY) begin
                if (reads_left > 0) begin
                    m_data_out <= '0;
                    reads_left <= reads_left - 1;
                end else begin
                    m_data_out <= 32'h1;
                end
            end else if (m_address == SPI_RX) begin
                m_data_out <= rx_q;
            end
        end
    end

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [NR-1:0] pend = '0;
    logic [31:0] words[NR];
    int          last_g = NR - 1;
    logic [31:0] slave_prev = '0;

    typedef struct {
        int          req;
        logic [31:0] word;
        int          delay;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] p, input int last);
        for (int k = 1; k <= NR; k++) begin
            int i;
            i = (last + k) % NR;
            if (p[i]) return i;
        end
        return -1;
    endfunction

    task automatic drive();
        req_valid = pend;
        for (int i = 0; i < NR; i++) req_data[i*32 +: 32] = words[i];
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 64'({req_ready, rsp_valid, rsp_err, busy, m_address, m_sel, m_we}), 0);
        check({tag, "_rsp_data"}, 64'(rsp_data), 0);
        check({tag, "_m_data_in"}, 64'(m_data_in), 0);
    endtask

    task automatic check_init_write(input string tag);
        check({tag, "_sel_we_busy"}, 64'({m_sel, m_we, busy}), 64'b111);
        check({tag, "_addr"}, 64'(m_address), 64'(SPI_INTRRPT_EN));
        check({tag, "_data"}, 64'(m_data_in), 0);
    endtask

    // Serves the next grant predicted by the model; keep leaves the winner requesting a new word.
    task automatic serve_one(input int d, input bit keep, output int g_act,
                             output logic [31:0] rd, output logic re, output int lat);
        int          g_exp;
        int          n;
        bit          seen;
        logic [31:0] exp_d;
        logic        exp_e;
        int          exp_lat;
        g_exp = rr_pick(pend, last_g);
        g_act = -1;
        rd    = 'x;
        re    = 1'bx;
        lat   = 0;
        seen  = 0;
        n     = 0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            if (req_ready != 0) seen = 1;
        end
        check("ready_seen", 64'(seen), 1);
        if (!seen) return;
        for (int i = 0; i < NR; i++) if (req_ready[i]) g_act = i;
        check("grant", 64'(req_ready), 64'(1) << g_exp);
        check("tx_word", 64'(m_data_in), 64'(words[g_exp]));
        ready_delay = d;
        exp_e   = (d >= TO);
        exp_d   = exp_e ? 32'h0 : slave_prev;
        exp_lat = exp_e ? 2 * TO + 2 : 6 + 2 * d;
        slave_prev = words[g_exp];
        if (keep) words[g_exp] = $urandom;
        else pend[g_exp] = 1'b0;
        drive();
        seen = 0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (rsp_valid != 0) seen = 1;
        end
        check("rsp_seen", 64'(seen), 1);
        if (!seen) return;
        rd = rsp_data;
        re = rsp_err;
        check("rsp_onehot", 64'(rsp_valid), 64'(1) << g_exp);
        check("rsp_data", 64'(rsp_data), 64'(exp_d));
        check("rsp_err", 64'(rsp_err), 64'(exp_e));
        check("latency", 64'(lat), 64'(exp_lat));
        last_g = g_exp;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1);
    end

    initial begin
        int          g;
        int          lat;
        int          d;
        bit          flag;
        bit          seen;
        logic [31:0] rd;
        logic        re;

        tbl[0] = '{1, 32'hF0F0F0F0, 0,  32'h000000B3, 1'b0, 6};
        tbl[1] = '{1, 32'h00000000, 0,  32'hF0F0F0F0, 1'b0, 6};
        tbl[2] = '{2, 32'h12345678, 3,  32'h00000000, 1'b0, 12};
        tbl[3] = '{0, 32'hDEADBEEF, 16, 32'h00000000, 1'b1, 34};
        tbl[4] = '{3, 32'hCAFEBABE, 15, 32'hDEADBEEF, 1'b0, 36};
        tbl[5] = '{0, 32'h00000005, 1,  32'hCAFEBABE, 1'b0, 8};
        for (int i = 0; i < NR; i++) words[i] = '0;

        // Reset, then the single INIT write, then a quiet IDLE.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        #1 check_init_write("init");
        flag = 0;
        repeat (10) begin
            @(negedge clk);
            flag |= busy | m_sel | m_we | (|req_ready) | (|rsp_valid) | (m_address != 0);
        end
        check("idle_quiet", 64'(flag), 0);

        // Withdrawal in the ARB cycle.
        req_valid[2] = 1'b1;
        @(negedge clk);
        check("withdraw_in_arb", 64'(busy), 1);
        req_valid[2] = 1'b0;
        flag = 0;
        repeat (8) begin
            @(negedge clk);
            flag |= (|req_ready) | m_we;
        end
        check("withdraw_no_wr", 64'(flag), 0);
        check("withdraw_idle", 64'(busy), 0);

        // Contention: all four at once, then 1 and 3.
        for (int i = 0; i < NR; i++) words[i] = 32'hA0 + 32'(i);
        pend = 4'hF;
        drive();
        for (int i = 0; i < NR; i++) begin
            serve_one(0, 1'b0, g, rd, re, lat);
            check("contention_order", 64'(g), 64'(i));
        end
        words[1] = 32'hB1;
        words[3] = 32'hB3;
        pend = 4'b1010;
        drive();
        serve_one(0, 1'b0, g, rd, re, lat);
        check("round2_first", 64'(g), 1);
        serve_one(0, 1'b0, g, rd, re, lat);
        check("round2_second", 64'(g), 3);

        // Table of single-requester transfers, including timeout and last-poll success.
        for (int t = 0; t < 6; t++) begin
            words[tbl[t].req] = tbl[t].word;
            pend = '0;
            pend[tbl[t].req] = 1'b1;
            drive();
            serve_one(tbl[t].delay, 1'b0, g, rd, re, lat);
            check("tbl_grant", 64'(g), 64'(tbl[t].req));
            check("tbl_data", 64'(rd), 64'(tbl[t].exp_data));
            check("tbl_err", 64'(re), 64'(tbl[t].exp_err));
            check("tbl_lat", 64'(lat), 64'(tbl[t].exp_lat));
        end

        // Randomized traffic against the round-robin model.
        for (int it = 0; it < 30; it++) begin
            if (pend == 0) begin
                pend = NR'($urandom_range(1, 15));
                for (int i = 0; i < NR; i++) if (pend[i]) words[i] = $urandom;
                drive();
            end
            d = ($urandom_range(0, 7) == 0) ? TO + int'($urandom_range(0, 3))
                                            : int'($urandom_range(0, 4));
            serve_one(d, $urandom_range(0, 3) == 0, g, rd, re, lat);
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i]  = 1'b1;
                    words[i] = $urandom;
                end
            end
            drive();
        end
        while (pend != 0) serve_one(0, 1'b0, g, rd, re, lat);

        // Reset asserted while polling READY.
        ready_delay = 1000;
        words[1] = 32'h13579BDF;
        pend = 4'b0010;
        drive();
        seen = 0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            if (m_sel && !m_we && m_address == SPI_READY) seen = 1;
        end
        check("poll_reached", 64'(seen), 1);
        #2 rst = 1'b0;
        #1 check_all_zero("mid_reset");
        pend = '0;
        drive();
        slave_prev = words[1];
        last_g = NR - 1;
        flag = 0;
        repeat (3) begin
            @(negedge clk);
            flag |= |rsp_valid;
        end
        rst = 1'b1;
        #1 check_init_write("reinit");
        repeat (40) begin
            @(negedge clk);
            flag |= |rsp_valid;
        end
        check("no_rsp_after_abort", 64'(flag), 0);
        ready_delay = 0;
        words[2] = 32'h2468ACE0;
        pend = 4'b0100;
        drive();
        serve_one(0, 1'b0, g, rd, re, lat);
        check("post_reset_data", 64'(rd), 64'h13579BDF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
